seg_scan_ctrl: RTL and testbench

- Parametrised multiplexed 7-segment scan driver for the board display.
- Holds a writable per-digit code/dp register file, decodes hex plus '-' and blank, and strobes NUM_DIGITS digits one at a time at a programmable rate.
- Adds scan enable, leading-zero suppression and a frame pulse. Sits between host logic and the digit/segment pins.

---
 rtl/seg_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan driver with per-digit code/dp register file.
// Optional blink support is compiled in when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned SCAN_DIV     = 1000
`ifdef SEG_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [4:0]            wr_code,
    input  logic                  wr_dp,
    input  logic                  lz_blank,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [NUM_DIGITS-1:0] digit,
    output logic [7:0]            seg_data,
    output logic                  frame_tick
);

    localparam int unsigned PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    logic [4:0]            code_q [NUM_DIGITS];
    logic                  dp_q   [NUM_DIGITS];
    logic [CNT_W-1:0]      cnt_q;
    logic [PTR_W-1:0]      ptr_q;
    logic                  tick;
    logic                  wrap;
    logic                  lz_run;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] digit_next;
    logic [7:0]            seg_next;

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'h7E;
            5'd1:    s = 7'h30;
            5'd2:    s = 7'h6D;
            5'd3:    s = 7'h79;
            5'd4:    s = 7'h33;
            5'd5:    s = 7'h5B;
            5'd6:    s = 7'h5F;
            5'd7:    s = 7'h70;
            5'd8:    s = 7'h7F;
            5'd9:    s = 7'h7B;
            5'd10:   s = 7'h77;
            5'd11:   s = 7'h1F;
            5'd12:   s = 7'h4E;
            5'd13:   s = 7'h3D;
            5'd14:   s = 7'h4F;
            5'd15:   s = 7'h47;
            5'd16:   s = 7'h01;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign tick = en && (cnt_q == LAST_CNT);
    assign wrap = tick && (ptr_q == LAST_PTR);

    // lz_mask[i] is set when positions 0..i all hold code 0.
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lz_run     = lz_run & (code_q[i] == 5'd0);
            lz_mask[i] = lz_run;
        end
    end

    always_comb begin
        digit_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_next[NUM_DIGITS-1-i] = (ptr_q == PTR_W'(i));
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] blink_cnt_q;
    logic             blink_on_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == LAST_BLK) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        seg_next = {decode(code_q[ptr_q]), dp_q[ptr_q]};
        // The last position is always shown so an all-zero value still reads "0".
        if (lz_blank && lz_mask[ptr_q] && (ptr_q != LAST_PTR)) begin
            seg_next[7:1] = 7'd0;
        end
`ifdef SEG_BLINK_EN
        if (!blink_on_q && blink_mask[ptr_q]) begin
            seg_next = 8'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                code_q[i] <= 5'd31;
                dp_q[i]   <= 1'b0;
            end
            cnt_q      <= '0;
            ptr_q      <= '0;
            digit      <= '0;
            seg_data   <= '0;
            frame_tick <= 1'b0;
        end else begin
            // Addresses at or beyond NUM_DIGITS match no entry and are dropped.
            if (wr_en) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (wr_addr == ADDR_W'(i)) begin
                        code_q[i] <= wr_code;
                        dp_q[i]   <= wr_dp;
                    end
                end
            end
            if (en) begin
                cnt_q      <= tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    ptr_q <= wrap ? '0 : ptr_q + 1'b1;
                end
                digit      <= digit_next;
                seg_data   <= seg_next;
                frame_tick <= wrap;
            end else begin
                cnt_q      <= '0;
                ptr_q      <= '0;
                digit      <= '0;
                seg_data   <= '0;
                frame_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-level reference model predicts each
// edge's outputs from elapsed scan time and a shadow register file.
module tb_seg_scan_ctrl;

    localparam int N  = 8;
    localparam int SD = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [4:0]    wr_code = '0;
    logic          wr_dp = 1'b0;
    logic          lz_blank = 1'b0;
    logic [N-1:0]  digit;
    logic [7:0]    seg_data;
    logic          frame_tick;

    typedef struct packed {
        logic [7:0] dig;
        logic [7:0] seg;
        logic       ft;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    int         run;
    int         pos;
    int         a;
    bit         supp;
    exp_t       m_e;
    exp_t       mon_e;
    logic [4:0] m_code [N];
    logic       m_dp   [N];

    seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .ADDR_W     (AW),
        .SCAN_DIV   (SD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_code    (wr_code),
        .wr_dp      (wr_dp),
        .lz_blank   (lz_blank),
`ifdef SEG_BLINK_EN
        .blink_mask ('0),
`endif
        .digit      (digit),
        .seg_data   (seg_data),
        .frame_tick (frame_tick)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [4:0] c);
        case (c)
            5'd0:  return 7'h7E;
            5'd1:  return 7'h30;
            5'd2:  return 7'h6D;
            5'd3:  return 7'h79;
            5'd4:  return 7'h33;
            5'd5:  return 7'h5B;
            5'd6:  return 7'h5F;
            5'd7:  return 7'h70;
            5'd8:  return 7'h7F;
            5'd9:  return 7'h7B;
            5'd10: return 7'h77;
            5'd11: return 7'h1F;
            5'd12: return 7'h4E;
            5'd13: return 7'h3D;
            5'd14: return 7'h4F;
            5'd15: return 7'h47;
            5'd16: return 7'h01;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    // Reference model: cycle c of continuous scanning shows position (c/SD)%N,
    // and the frame pulse follows the last cycle of each N*SD-cycle frame.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            run = 0;
            for (int i = 0; i < N; i++) begin
                m_code[i] = 5'd31;
                m_dp[i]   = 1'b0;
            end
        end else begin
            m_e = '0;
            if (en) begin
                pos = (run / SD) % N;
                m_e.dig = '0;
                m_e.dig[N-1-pos] = 1'b1;
                supp = lz_blank && (pos != N-1);
                for (int k = 0; k <= pos; k++) begin
                    if (m_code[k] != 5'd0) supp = 1'b0;
                end
                m_e.seg = {supp ? 7'd0 : ref_seg(m_code[pos]), m_dp[pos]};
                m_e.ft  = ((run % (SD * N)) == SD * N - 1);
                run++;
            end else begin
                run = 0;
            end
            q.push_back(m_e);
            a = int'(wr_addr);
            if (wr_en && a < N) begin
                m_code[a] = wr_code;
                m_dp[a]   = wr_dp;
            end
        end
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("digit", digit, mon_e.dig);
            check("seg_data", seg_data, mon_e.seg);
            check("frame_tick", {7'd0, frame_tick}, {7'd0, mon_e.ft});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int addr, input int code, input bit dp);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_code = 5'(code);
        wr_dp   = dp;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_digit(input logic [7:0] want, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (digit == want) found = 1'b1;
            else @(negedge clk);
        end
        check(name, {7'd0, found}, 8'd1);
    endtask

    int ft_seen;
    int codes [N] = '{1, 9, 9, 6, 0, 4, 1, 3};
    bit dps   [N] = '{0, 0, 0, 1, 0, 1, 0, 1};
    int lzpat [N] = '{0, 0, 0, 5, 0, 0, 0, 0};

    initial begin
        // Reset state
        cyc(2);
        check("rst_digit", digit, 8'h00);
        check("rst_seg", seg_data, 8'h00);
        check("rst_ft", {7'd0, frame_tick}, 8'h00);
        reset = 1'b1;
        cyc(2);

        // Basic scan with the reference digit pattern
        en = 1'b1;
        for (int i = 0; i < N; i++) wr(i, codes[i], dps[i]);
        cyc(64);

        // Free-run: exactly three frame pulses in 3 frames
        ft_seen = 0;
        repeat (3 * N * SD) begin
            @(negedge clk);
            if (frame_tick) ft_seen++;
        end
        check("frame_count", 8'(ft_seen), 8'd3);

        // Leading-zero suppression
        lz_blank = 1'b1;
        for (int i = 0; i < N; i++) wr(i, lzpat[i], 1'b0);
        cyc(40);
        for (int i = 0; i < N; i++) wr(i, 0, 1'b0);
        cyc(40);
        lz_blank = 1'b0;

        // Drop enable while position 3 is shown, then re-enable
        wait_digit(8'h10, "find_pos3");
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(40);

        // Out-of-range writes, then a write to the displayed position
        for (int i = 8; i < 16; i++) wr(i, 14, 1'b1);
        cyc(40);
        wait_digit(8'h08, "find_pos4");
        wr(4, 14, 1'b0);
        cyc(10);

        // Randomised traffic
        repeat (600) begin
            en      = ($urandom % 16) != 0;
            wr_en   = ($urandom % 3) == 0;
            wr_addr = AW'($urandom);
            wr_code = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            wr_dp   = 1'($urandom);
            if (($urandom % 50) == 0) lz_blank = ~lz_blank;
            @(negedge clk);
        end
        wr_en    = 1'b0;
        en       = 1'b1;
        lz_blank = 1'b0;
        cyc(20);

        // Asynchronous reset mid-scan
        check("pre_rst_active", {7'd0, digit != '0}, 8'd1);
        #2 reset = 1'b0;
        #1;
        check("async_digit", digit, 8'h00);
        check("async_seg", seg_data, 8'h00);
        check("async_ft", {7'd0, frame_tick}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        cyc(40);

        check("sb_volume", {7'd0, n_cmp >= 3000}, 8'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
